// File: rtl/bitheap_bist_driver.sv
// bitheap_bist_driver: on-board self-test driver for the one-stage bitheap
// compressor of the N x N multiplier. It issues LFSR-derived operand pairs
// as a registered partial-product bitheap. It checks the compressor sum
// against a locally computed a*b, LAT cycles later.
// Optional build macro: BIST_CORNER_EN. When defined, the first (up to) four
// vectors are the fixed corner operands, and then the LFSR vectors follow.
module bitheap_bist_driver #(
  parameter int N     = 22,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vectors,
  input  logic [2*N-1:0]     seed,
  output logic [N*N-1:0]     pp_bits,
  input  logic [2*N:0]       comp_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   first_err_idx
);

  localparam int W2 = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [W2-1:0]    lfsr;
  logic [W2-1:0]    lfsr_next;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] issue_cnt;
  logic [3:0]       drain_cnt;

  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             lfsr_adv;
  logic [W2-1:0]    prod;

  logic             start_acc;
  logic             issue;
  logic             last_issue;
  logic             mism;

  // Expected-product delay line; the valid bit and vector index travel with it.
  logic [W2-1:0]    exp_p [LAT];
  logic [CNT_W-1:0] tag_p [LAT];
  logic             vld_p [LAT];

  // The top sum bit cannot be set by an N x N product and is never compared.
  logic             sum_msb_unused;
  assign sum_msb_unused = comp_in[W2];

  // Saturating increment for the mismatch counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + 1'b1;
  endfunction

  // Unsigned partial-product bitheap: bit i*N+j = a[j] & b[i], weight i+j.
  function automatic logic [N*N-1:0] build_pp(input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    logic [N*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        r[i*N+j] = a[j] & b[i];
      end
    end
    return r;
  endfunction

  assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
  assign issue      = (state == S_RUN) && (num_lat != '0);
  assign last_issue = issue && (issue_cnt == num_lat - 1'b1);

  // Fibonacci shift-left; taps 44,43,18,17 give a maximal sequence at 2N=44.
  assign lfsr_next = {lfsr[W2-2:0], lfsr[W2-1] ^ lfsr[W2-2] ^ lfsr[17] ^ lfsr[16]};

  // Operand selection: LFSR halves, or the fixed corner set at the head of a run.
  always_comb begin
    op_a     = lfsr[N-1:0];
    op_b     = lfsr[W2-1:N];
    lfsr_adv = 1'b1;
`ifdef BIST_CORNER_EN
    if (issue_cnt < CNT_W'(4)) begin
      lfsr_adv = 1'b0;
      case (issue_cnt[1:0])
        2'd0:    begin op_a = '0;            op_b = '0;            end
        2'd1:    begin op_a = '1;            op_b = '1;            end
        2'd2:    begin op_a = '1;            op_b = N'(1);         end
        default: begin op_a = N'(1);         op_b = '1;            end
      endcase
    end
`endif
  end

  assign prod = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (num_lat == '0)   state_nxt = S_DONE;
        else if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == 4'(LAT - 1)) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Run control: operand latch, LFSR, issue and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= W2'(1);
      num_lat   <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_acc) begin
        lfsr      <= (seed == '0) ? W2'(1) : seed;
        num_lat   <= num_vectors;
        issue_cnt <= '0;
      end else if (issue) begin
        if (lfsr_adv) lfsr <= lfsr_next;
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;
    end
  end

  // Issue stage: registered bitheap, held between issues.
  always_ff @(posedge clk) begin
    if (rst)        pp_bits <= '0;
    else if (issue) pp_bits <= build_pp(op_a, op_b);
  end

  // Delay line valid bits: one stage per cycle of compressor latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Delay line data: expected product and vector index.
  always_ff @(posedge clk) begin
    exp_p[0] <= prod;
    tag_p[0] <= issue_cnt;
    for (int k = 1; k < LAT; k++) begin
      exp_p[k] <= exp_p[k-1];
      tag_p[k] <= tag_p[k-1];
    end
  end

  assign mism = vld_p[LAT-1] && (comp_in[W2-1:0] != exp_p[LAT-1]);

  // Check stage: error count, first failing index, pass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt       <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else begin
      if (start_acc) begin
        err_cnt       <= '0;
        first_err_idx <= '1;
        pass          <= 1'b0;
      end else begin
        if (mism) begin
          err_cnt <= sat_inc(err_cnt);
          if (first_err_idx == {CNT_W{1'b1}}) first_err_idx <= tag_p[LAT-1];
        end
        if ((state != S_DONE) && (state_nxt == S_DONE))
          pass <= (err_cnt == '0) && !mism;
      end
    end
  end

endmodule

// File: doc/bitheap_bist_driver.md
Name: bitheap_bist_driver

Overview:
- Hardware stimulus/checker for the one-stage bitheap compressor used in the N x N multiplier; it drives the compressor inputs and reads its output.
- Generates pseudo-random operand pairs (a, b) from an LFSR, drives the unsigned partial-product bitheap, and compares the returned compressor sum against a locally computed a*b after a fixed pipeline latency.
- Reports pass/fail, error count and first failing index; used for on-board self-test of compressor netlists.

Parameters:
- N, 22, operand width in bits.
- LAT, 1, compressor latency in cycles from pp_bits change to valid comp_in; range 1..8.
- CNT_W, 16, width of vector counter, error counter and index outputs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start request; sampled only in IDLE or DONE.
- num_vectors  in  CNT_W  number of vectors to issue; latched on accepted start.
- seed  in  2N  LFSR seed; latched on accepted start. Value 0 is replaced by 1.
- pp_bits  out  N*N  registered partial products; pp_bits[i*N+j] = a[j] & b[i], weight i+j.
- comp_in  in  2N+1  compressor sum output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next accepted start or rst.
- pass  out  1  valid when done=1; 1 iff err_cnt == 0.
- err_cnt  out  CNT_W  mismatch count, saturating at all-ones.
- first_err_idx  out  CNT_W  index of the first mismatching vector; all-ones if none.

Behaviour:
- Reset values: pp_bits=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=all-ones, state=IDLE, LFSR=1. A mid-run rst aborts immediately, with no done pulse.
- States:
  - IDLE/DONE --(start)--> RUN. On entry to RUN, clear err_cnt and first_err_idx, latch num_vectors and seed, and clear issue_cnt.
  - If the latched num_vectors == 0, go from RUN to DONE in the next cycle with pass=1, and drive no vectors.
- RUN, each cycle:
  - a = lfsr[N-1:0], b = lfsr[2N-1:N].
  - pp_bits is registered from a and b; expected a*b (2N bits) is pushed into a LAT-deep delay line tagged with issue_cnt.
  - The LFSR advances: Fibonacci, shift left, new bit0 = lfsr[43]^lfsr[42]^lfsr[17]^lfsr[16] for N=22 (taps 44,43,18,17).
  - issue_cnt increments.
  - After num_vectors issues, go to DRAIN.
- Vector k is on pp_bits from cycle t_k. comp_in is sampled at edge t_k+LAT and compared against the delay-line output on bits [2N-1:0]; bit 2N is ignored.
- Compare-valid travels with the delay line, so no compare occurs before the first vector arrives or after the last.
- DRAIN: pp_bits holds its last value. Stay in DRAIN until the last vector's compare is done (LAT cycles), then go to DONE.
- On mismatch:
  - err_cnt++ (saturating).
  - first_err_idx is written only while it is all-ones.
  - If the first mismatch and the all-ones index coincide (index = 2^CNT_W-1), the index stays all-ones; this is accepted.
- done and pass update on the DONE entry edge.
- A start while in RUN or DRAIN is ignored.
- In DONE, a start restarts immediately. In that cycle done drops and busy rises.

Optional Feature:
- BIST_CORNER_EN
- Defined: the first min(4, num_vectors) vectors are the fixed corner operands, in order:
  - (0, 0)
  - (2^N-1, 2^N-1)
  - (2^N-1, 1)
  - (1, 2^N-1)
- The LFSR does not advance during the corner vectors. Random vectors follow, so the total stays num_vectors.
- Not defined: all vectors come from the LFSR.

Test Plan:
- Ideal compressor model (comp_in = popcount-weighted sum of pp_bits, delayed LAT=1), seed=1, num_vectors=100 -> busy for 101 cycles, done=1, pass=1, err_cnt=0, first_err_idx=0xFFFF.
- Model with comp_in[5] forced to 1, num_vectors=20 -> err_cnt equals the number of vectors with product bit5 = 0, and first_err_idx equals the lowest such index.
- num_vectors=0, start -> done=1 one cycle later, pass=1, and pp_bits is never changed from 0.
- seed=0, num_vectors=3 -> operands equal those of seed=1. Vector 0 has a=1, b=0, so pp_bits=0 and the expected product is 0.
- rst asserted at vector 7 of 50 -> all outputs at reset values the next cycle. A restart with the same seed reproduces an identical vector sequence.
- BIST_CORNER_EN, num_vectors=4, LAT=3 -> pp_bits is all-zeros, then all-ones, then bits with i=0 set, then bits with j=0 set. Expected values are 0, (2^22-1)^2, 2^22-1, 2^22-1, and pass=1.
